hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory hold, halt
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int REG_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             halt,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_cycles
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    logic [1:0] state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        flush        = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        if (!rst_n) begin
            pc_write     = 1'b0;
            flush        = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = ST_RUN;
            cnt_nxt      = 3'd0;
        end else if (state == ST_HALTED) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (halt) begin
            pc_write     = 1'b0;
            flush        = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = ST_HALTED;
        end else if (mem_busy) begin
            // Everything frozen; pending branch/load-use re-evaluated once memory is ready.
            pc_write  = 1'b0;
            pipe_hold = 1'b1;
        end else begin
            case (state)
                ST_FLUSH: begin
                    flush        = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (cnt <= 3'd1) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                ST_LU_STALL: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    if (branch_taken) begin
                        flush = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            state_nxt = ST_FLUSH;
                            cnt_nxt   = 3'(BRANCH_PENALTY - 1);
                        end
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_nxt    = ST_LU_STALL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
            flush_cycles <= 16'd0;
        end else begin
            if ((state != ST_HALTED) && !pc_write && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (flush && (flush_cycles != 16'hFFFF))
                flush_cycles <= flush_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized + directed bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int BP = 3;

    logic       clk = 1'b0;
    logic       rst_n, ex_mem_read, branch_taken, mem_busy, halt;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_write, IF_ID_write, flush, id_ex_bubble, pipe_hold;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: machine is either halted, draining flush cycles, one cycle past a stall, or running.
    bit m_halted;
    bit m_after_stall;
    int m_flush_left;
    int m_stall_cnt;
    int m_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.BRANCH_PENALTY(BP), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .halt(halt), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .flush(flush), .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic h, input logic mb, input logic br,
                       input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert);
        logic [4:0] exp;
        bit lu;
        @(negedge clk);
        rst_n = r; halt = h; mem_busy = mb; branch_taken = br;
        ex_mem_read = mr; id_rs = rs; id_rt = rt; ex_rt = ert;
        #1;
        lu = mr && (ert != 0) && (ert == rs || ert == rt);
        // {pc_write, IF_ID_write, flush, id_ex_bubble, pipe_hold}
        if (!r)                    exp = 5'b01110;
        else if (m_halted)         exp = 5'b00010;
        else if (h)                exp = 5'b01110;
        else if (mb)               exp = 5'b01001;
        else if (m_flush_left > 0) exp = 5'b11110;
        else if (m_after_stall)    exp = 5'b11000;
        else if (br)               exp = 5'b11100;
        else if (lu)               exp = 5'b01010;
        else                       exp = 5'b11000;
        check("outs", {27'd0, pc_write, IF_ID_write, flush, id_ex_bubble, pipe_hold}, {27'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles", {16'd0, stall_cycles}, m_stall_cnt);
        check("flush_cycles", {16'd0, flush_cycles}, m_flush_cnt);
`endif
        @(posedge clk);
        if (!r) begin
            m_halted = 0; m_after_stall = 0; m_flush_left = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (!m_halted && !exp[4] && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
            if (exp[2] && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
            if (m_halted) begin
            end else if (h) m_halted = 1;
            else if (mb) begin
            end else if (m_flush_left > 0) m_flush_left--;
            else if (m_after_stall) m_after_stall = 0;
            else if (br) m_flush_left = BP - 1;
            else if (lu) m_after_stall = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        m_halted = 0; m_after_stall = 0; m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        rst_n = 0; halt = 0; mem_busy = 0; branch_taken = 0; ex_mem_read = 0;
        id_rs = 0; id_rt = 0; ex_rt = 0;
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd3);
        idle(2);
        // Load-use held for two cycles: only one bubble.
        cyc(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5);
        cyc(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5);
        cyc(1, 0, 0, 0, 1, 5'd1, 5'd7, 5'd7);
        idle(1);
        // Register zero never stalls.
        cyc(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        idle(1);
        // Branch pulse: three flush cycles.
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle(4);
        // Memory busy across flush cycle two.
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(3);
        // Halt with branch, then reset out of HALTED.
        cyc(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle(3);
        cyc(1, 0, 1, 1, 1, 5'd2, 5'd2, 5'd2);
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(2);
        // Reset mid-flush discards remaining flush cycles.
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 100) != 0, ($urandom % 150) == 0, ($urandom % 5) == 0,
                ($urandom % 6) == 0, ($urandom % 2) == 0,
                5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
